// File: rtl/keypad_serial_tx.sv
// Keypad press queue and UART 8N1 transmitter: each debounced key press is
// buffered in a small FIFO and sent on the serial line as its ASCII hex digit.
module keypad_serial_tx #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 9600,
  parameter int BAUD_DIV   = CLK_HZ / BAUD,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                key_valid_,
  input  logic [3:0]          key_code,
  output logic                tx,
  output logic                busy,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] fifo_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int BW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] code);
    logic [7:0] w_code;
    w_code = {4'h0, code};
    if (code < 4'd10) begin
      return 8'h30 + w_code;
    end else begin
      return 8'h37 + w_code;
    end
  endfunction

  logic                  r_s1, r_s2, r_s3;
  logic [3:0]            r_code1, r_code2;
  logic [3:0]            r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  state_t                r_state;
  logic [BW-1:0]         r_baud;
  logic [2:0]            r_bit;
  logic [7:0]            r_shift;
  logic                  r_tx;

  logic       w_press, w_pop, w_full, w_push, w_drop, w_baud_done;
  logic [3:0] w_head;

  assign w_press     = !r_s2 && r_s3;
  assign w_pop       = (r_state == ST_IDLE) && (r_count != {CW{1'b0}});
  assign w_full      = (r_count == COUNT_FULL);
  assign w_push      = w_press && (!w_full || w_pop);
  assign w_drop      = w_press && w_full && !w_pop;
  assign w_head      = r_mem[r_rptr];
  assign w_baud_done = (r_baud == BAUD_LAST);

  // Two-flop synchronizer for the asynchronous scanner outputs, plus edge history
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_s3    <= 1'b1;
      r_code1 <= 4'h0;
      r_code2 <= 4'h0;
    end else begin
      r_s1    <= key_valid_;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_code1 <= key_code;
      r_code2 <= r_code1;
    end
  end

  // FIFO storage; contents are meaningless until the count says otherwise
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_code2;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wptr     <= {DEPTH_LOG2{1'b0}};
      r_rptr     <= {DEPTH_LOG2{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Transmit FSM; tx is updated on the same edge the state changes
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
      r_baud  <= {BW{1'b0}};
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= hex_ascii(w_head);
            r_baud  <= {BW{1'b0}};
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_baud_done) begin
            r_baud  <= {BW{1'b0}};
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud <= {BW{1'b0}};
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_done) begin
            r_baud  <= {BW{1'b0}};
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
  assign busy       = (r_state != ST_IDLE) || (r_count != {CW{1'b0}});

endmodule

// File: tb/tb_keypad_serial_tx.sv
// Self-checking bench for keypad_serial_tx: directed scenarios plus random presses,
// compared every clock against an edge-level reference model of queue and line.
module tb_keypad_serial_tx;
  localparam int BD = 4;
  localparam int FRAME = 10 * BD;

  logic       clk = 1'b0;
  logic       reset_;
  logic       key_valid_;
  logic [3:0] key_code;
  logic       tx, busy, overflow;
  logic [2:0] fifo_count;

  keypad_serial_tx #(.CLK_HZ(40), .BAUD(10), .BAUD_DIV(BD), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset_(reset_), .key_valid_(key_valid_), .key_code(key_code),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ecount = 0;

  // reference model: sampled key history, queued codes, current frame
  logic       h1, h2, h3;
  logic [3:0] c1, c2;
  logic [3:0] m_q[$];
  bit         m_on;
  int         m_start;
  logic [7:0] m_cur;
  bit         m_ovf;
  logic [7:0] exp_bytes[$];

  // line decoder working on the observed tx
  logic [7:0] rx_q[$];
  bit         rx_in = 1'b0;
  int         rx_cnt;
  logic [7:0] rx_byte;
  int         fall_edge = 0;
  int         busy_low_edge = 0;
  logic       prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ascii(input logic [3:0] c);
    if (c <= 4'd9) return 8'(48 + int'(c));
    else return 8'(65 + int'(c) - 10);
  endfunction

  function automatic bit m_active();
    return m_on && (ecount - m_start < FRAME);
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_active()) return 1'b1;
    k = ecount - m_start;
    if (k < BD) return 1'b0;
    if (k < 9 * BD) return m_cur[(k - BD) / BD];
    return 1'b1;
  endfunction

  task automatic model_reset();
    h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    c1 = 4'h0; c2 = 4'h0;
    m_q.delete();
    m_on = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic kv, input logic [3:0] code);
    bit press, idle, pop;
    int cnt;
    press = (h2 == 1'b0) && (h3 == 1'b1);
    idle  = !m_on || (ecount - 1 - m_start >= FRAME);
    cnt   = m_q.size();
    pop   = idle && (cnt > 0);
    if (pop) begin
      m_cur = ascii(m_q.pop_front());
      m_start = ecount;
      m_on = 1'b1;
      exp_bytes.push_back(m_cur);
    end
    if (press) begin
      if (cnt < 4 || pop) m_q.push_back(c2);
      else m_ovf = 1'b1;
    end
    h3 = h2; h2 = h1; h1 = kv;
    c2 = c1; c1 = code;
  endtask

  task automatic decode();
    if (prev_busy === 1'b1 && busy === 1'b0) busy_low_edge = ecount;
    prev_busy = busy;
    if (!rx_in) begin
      if (tx === 1'b0) begin
        rx_in = 1'b1;
        rx_cnt = 0;
        fall_edge = ecount;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_byte[(rx_cnt - 6) / 4] = tx;
      if (rx_cnt == 38) begin
        chk("stop_bit", 32'(tx), 32'(1));
        rx_q.push_back(rx_byte);
      end
      if (rx_cnt == 39) rx_in = 1'b0;
    end
  endtask

  task automatic tick(input logic kv, input logic [3:0] code);
    key_valid_ = kv;
    key_code = code;
    @(posedge clk);
    ecount++;
    model_edge(kv, code);
    #1;
    chk("tx", 32'(tx), 32'(m_tx()));
    chk("busy", 32'(busy), 32'(m_active() || (m_q.size() != 0)));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    decode();
  endtask

  task automatic press(input logic [3:0] code, input int lo, input int hi);
    repeat (lo) tick(1'b0, code);
    repeat (hi) tick(1'b1, code);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_active()) && n < 3000) begin
      tick(1'b1, 4'h0);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $error("FAIL drain_timeout observed=%0d expected<3000", n);
    end
    repeat (3) tick(1'b1, 4'h0);
  endtask

  initial begin
    int e_low;
    logic [7:0] exp2 [3];
    exp2 = '{8'h41, 8'h43, 8'h46};

    // reset state
    reset_ = 1'b0;
    key_valid_ = 1'b1;
    key_code = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    chk("rst_fifo_count", 32'(fifo_count), 32'(0));
    reset_ = 1'b1;
    model_reset();
    repeat (5) tick(1'b1, 4'h0);

    // single press of code 5 held for 100 clocks
    rx_q.delete();
    e_low = ecount + 1;
    press(4'd5, 100, 3);
    drain();
    chk("t1_fall_latency", 32'(fall_edge - e_low), 32'(3));
    chk("t1_frame_to_idle", 32'(busy_low_edge - fall_edge), 32'(40));
    chk("t1_nframes", 32'(rx_q.size()), 32'(1));
    chk("t1_byte", 32'(rx_q[0]), 32'(8'h35));

    // letters, each after the previous frame has finished
    rx_q.delete();
    press(4'd10, 3, 3); drain();
    press(4'd12, 3, 3); drain();
    press(4'd15, 3, 3); drain();
    chk("t2_nframes", 32'(rx_q.size()), 32'(3));
    for (int i = 0; i < 3; i++) chk("t2_byte", 32'(rx_q[i]), 32'(exp2[i]));

    // push coincident with the idle pop while full
    rx_q.delete();
    for (int k = 1; k <= 5; k++) press(4'(k), 2, 3);
    while (ecount < m_start + 38) tick(1'b1, 4'h6);
    tick(1'b0, 4'h6);
    tick(1'b0, 4'h6);
    tick(1'b1, 4'h6);
    chk("t4_count_full", 32'(fifo_count), 32'(4));
    chk("t4_no_overflow", 32'(overflow), 32'(0));
    drain();
    chk("t4_nframes", 32'(rx_q.size()), 32'(6));
    for (int i = 0; i < 6; i++) chk("t4_byte", 32'(rx_q[i]), 32'(8'h31 + 8'(i)));

    // six quick presses: the sixth is dropped
    rx_q.delete();
    for (int k = 0; k <= 5; k++) press(4'(k), 2, 3);
    chk("t3_count", 32'(fifo_count), 32'(4));
    chk("t3_overflow", 32'(overflow), 32'(1));
    drain();
    chk("t3_nframes", 32'(rx_q.size()), 32'(5));
    for (int i = 0; i < 5; i++) chk("t3_byte", 32'(rx_q[i]), 32'(8'h30 + 8'(i)));
    chk("t3_overflow_sticky", 32'(overflow), 32'(1));

    // long hold gives exactly one frame
    rx_q.delete();
    press(4'd7, 5000, 3);
    drain();
    chk("t5_nframes", 32'(rx_q.size()), 32'(1));
    chk("t5_byte", 32'(rx_q[0]), 32'(8'h37));

    // reset during data bit 3 with two codes queued
    press(4'd8, 2, 3);
    press(4'd9, 2, 3);
    press(4'd10, 2, 3);
    while (ecount < m_start + 17) tick(1'b1, 4'h0);
    chk("t6_queued", 32'(fifo_count), 32'(2));
    #2 reset_ = 1'b0;
    #1;
    chk("t6_rst_tx", 32'(tx), 32'(1));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_fifo_count", 32'(fifo_count), 32'(0));
    chk("t6_rst_overflow", 32'(overflow), 32'(0));
    repeat (2) begin
      @(posedge clk);
      ecount++;
    end
    #1 reset_ = 1'b1;
    model_reset();
    rx_in = 1'b0;
    prev_busy = 1'b0;
    rx_q.delete();
    repeat (200) tick(1'b1, 4'h0);
    chk("t6_silent", 32'(rx_q.size()), 32'(0));
    press(4'd2, 2, 3);
    drain();
    chk("t6_nframes", 32'(rx_q.size()), 32'(1));
    chk("t6_byte", 32'(rx_q[0]), 32'(8'h32));

    // random presses against the model's byte stream
    rx_q.delete();
    exp_bytes.delete();
    for (int n = 0; n < 30; n++) begin
      press(4'($urandom_range(0, 15)), $urandom_range(1, 12), $urandom_range(1, 10));
    end
    drain();
    chk("rand_nframes", 32'(rx_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++) chk("rand_byte", 32'(rx_q[i]), 32'(exp_bytes[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_serial_tx.md
# keypad_serial_tx

Downstream consumer of the keypad scanner for the serial interface design. The block detects each debounced key press from the scanner's `key_valid_` and `key_code` outputs and queues the code in a small FIFO. It converts each queued code to its ASCII hex character and transmits it on a UART 8N1 line. This lets every press reach the host, even when presses arrive faster than the serial line drains them.

## Interface

Parameters:
- `CLK_HZ`, default 27000000: system clock frequency in Hz.
- `BAUD`, default 9600: serial bit rate.
- `BAUD_DIV`, default CLK_HZ/BAUD (integer truncation, 2812): clocks per bit. Must be ≥ 2.
- `DEPTH_LOG2`, default 2: FIFO depth is 2**DEPTH_LOG2 entries (4).

Ports:
- `clk`  in  1  system clock. All logic on the rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `key_valid_`  in  1  active-low key-valid from the scanner. Asynchronous to this block's logic.
- `key_code`  in  4  key code from the scanner. Stable while `key_valid_` is low.
- `tx`  out  1  UART serial output. Idles high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `overflow`  out  1  sticky. Set when a press is dropped because the FIFO is full.
- `fifo_count`  out  DEPTH_LOG2+1  number of queued codes, excluding the frame in flight.

## Operation

- Input sync:
  - `key_valid_` passes through two flops (s1, s2); s3 holds the previous s2.
  - `key_code` passes through two flops aligned with s1/s2.
  - On reset, s1/s2/s3 go to 1 and the code flops go to 0.
- Press event: s2==0 && s3==1, a single-cycle pulse.
  - Holding `key_valid_` low produces exactly one event.
  - Release (0→1) produces none.
- FIFO push on a press event, storing the synced code.
  - If count < DEPTH: push.
  - If count == DEPTH and a pop occurs in the same cycle: push is accepted and count is unchanged.
  - If count == DEPTH with no pop: the code is dropped and `overflow` is set to 1. It clears only on reset.
- Pointers: read and write pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Count ranges 0..DEPTH.
- ASCII conversion, applied at pop:
  - Codes 0–9 map to 0x30+code.
  - Codes 10–15 map to 0x41+(code−10), giving 'A'–'F'.
- TX FSM states: IDLE, START, DATA, STOP. A baud counter of 0..BAUD_DIV−1 and a 3-bit bit index are used.
  - IDLE: `tx`=1. If count≠0, pop, load the 8-bit shift register with the ASCII byte, clear the baud counter, and go to START.
  - START: `tx`=0 for BAUD_DIV clocks, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0]; bits go out LSB first.
    - Each bit lasts BAUD_DIV clocks.
    - After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for BAUD_DIV clocks, then go to IDLE.
- `tx` is a registered output.
- `busy` = (state≠IDLE) || (count≠0).
- Reset mid-operation: the frame is abandoned, `tx` goes to 1 immediately, and the FIFO empties. No partial frame resumes after reset.

## Timing

- Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, state=IDLE.
- Latency: if `key_valid_` is first sampled low at edge N:
  - s2 is low after N+1.
  - The push occurs at N+2, so `fifo_count`=1 after N+2 when the FIFO was empty and idle.
  - The pop occurs at N+3; `fifo_count` returns to 0 and `tx` falls after N+3.
- Frame length: exactly 10×BAUD_DIV clocks, from `tx` falling to the end of STOP.
- Back-to-back frames: after STOP ends, IDLE takes one clock, then `tx` falls. The inter-frame gap is 1 clock of high beyond the stop bit.
- Press rate: presses separated by ≥3 clocks of `key_valid_` high are each detected.

## Test plan

- Reset, then press code 5 (`key_valid_` low for 100 clocks), with BAUD_DIV=4 in sim:
  - `tx` falls 3 clocks after the first low sample.
  - The frame is 0x35: start, then bits 1,0,1,0,1,1,0,0, then stop, for 40 clocks total.
  - `busy` returns to 0 one clock after STOP ends.
- Press codes 10, 12 and 15 spaced past frame end: frames are 0x41, 0x43 and 0x46.
- Six presses (codes 0–5) within the first frame's duration:
  - Code 0 transmits, codes 1–4 are queued, and `fifo_count`=4.
  - Code 5 is dropped and `overflow`=1.
  - Frames 0x30–0x34 are sent in order. `overflow` stays 1 afterwards.
- Push coincident with an IDLE pop at count==DEPTH: the push is accepted, count stays 4, and no overflow occurs.
- Hold `key_valid_` low for 5000 clocks, then release: exactly one frame is sent.
- Assert `reset_` in the middle of DATA bit 3 with 2 codes queued:
  - `tx`=1, `busy`=0 and `fifo_count`=0 immediately.
  - After release, nothing is transmitted until a new press.
